// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/bus bundle between the ALU control logic (master) and the
// sequential binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  neg
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output neg
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define SIGNED_INPUT_EN to treat bin_in as two's complement and report the sign on neg.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    // True when DIGITS decimal digits can represent every WIDTH-bit value.
    function automatic bit digits_sufficient(input int w, input int d);
        logic [127:0] limit;
        logic [127:0] pow10;
        limit = 128'd1 << w;
        pow10 = 128'd1;
        for (int i = 0; i < d; i++) begin
            pow10 = pow10 * 128'd10;
        end
        return pow10 > limit;
    endfunction

    generate
        if (!digits_sufficient(WIDTH, DIGITS)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH (need 10^DIGITS > 2^WIDTH)");
        end
        if ($bits(bus.bin_in) != WIDTH || $bits(bus.bcd_out) != BW) begin : g_bad_bus
            $error("bin_to_bcd_seq: interface parameters do not match module parameters");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  shift_q;
    logic [BW-1:0]     scratch_q;
    logic [BW-1:0]     bcd_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  operand;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     scratch_d;
    logic [WIDTH-1:0]  shift_d;

`ifdef SIGNED_INPUT_EN
    logic              operand_neg;
    logic [WIDTH:0]    neg_mag;
    logic              sign_q;
    logic              neg_q;

    // Negate in WIDTH+1 bits so the most-negative input yields its true magnitude.
    assign neg_mag     = -{bus.bin_in[WIDTH-1], bus.bin_in};
    assign operand_neg = bus.bin_in[WIDTH-1];
    assign operand     = operand_neg ? neg_mag[WIDTH-1:0] : bus.bin_in;
`else
    assign operand     = bus.bin_in;
`endif

    // Add-3 correction on every scratch digit before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] digit;
            assign digit            = scratch_q[4*gi +: 4];
            assign adj[4*gi +: 4]   = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    assign {scratch_d, shift_d} = {adj, shift_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SIGNED_INPUT_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shift_q   <= operand;
                        scratch_q <= '0;
                        cnt_q     <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
`ifdef SIGNED_INPUT_EN
                        sign_q    <= operand_neg;
`endif
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q - CW'(1);
                    // Publish only the finished result; bcd_out never shows partial sums.
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= scratch_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef SIGNED_INPUT_EN
                        neg_q   <= sign_q;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
`ifdef SIGNED_INPUT_EN
    assign bus.neg     = neg_q;
`else
    assign bus.neg     = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against an arithmetic
// decimal-digit model; covers reset, latency, ignored starts, abort and back-to-back.
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Decimal digits of the (magnitude of the) operand, by division.
    function automatic logic [19:0] ref_bcd(input logic [15:0] v);
        int unsigned m;
        logic [19:0] r;
        m = v;
`ifdef SIGNED_INPUT_EN
        if (v[15]) m = 32'd65536 - v;
`endif
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_neg(input logic [15:0] v);
`ifdef SIGNED_INPUT_EN
        return v[15];
`else
        return 1'b0;
`endif
    endfunction

    // Present start for one edge, then scramble bin_in to prove it is not re-sampled.
    task automatic start_conv(input logic [15:0] v);
        bus.bin_in = v;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = 16'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("done_low_after_accept", 32'(bus.done), 32'd0);
    endtask

    // Called at the first negedge after acceptance; waits (bounded) for done.
    task automatic finish_conv(input logic [15:0] v, input bit poke);
        int k;
        int busy_cnt;
        bit got;
        k = 1;
        busy_cnt = 0;
        got = 1'b0;
        while (k <= 40 && !got) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                bus.start = poke && (k == 3 || k == 10);
                if (poke) bus.bin_in = 16'd42;
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        check("latency", 32'(k), 32'd17);
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("bcd_out", 32'(bus.bcd_out), 32'(ref_bcd(v)));
        check("neg", 32'(bus.neg), 32'(ref_neg(v)));
        $display("conv %04h -> bcd %05h neg %0b (expect %05h/%0b)",
                 v, bus.bcd_out, bus.neg, ref_bcd(v), ref_neg(v));
    endtask

    task automatic convert(input logic [15:0] v);
        start_conv(v);
        finish_conv(v, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        int gap;
        logic [15:0] v;
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd_out), 32'd0);
        check("rst_neg", 32'(bus.neg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(16'd1234);
`ifndef SIGNED_INPUT_EN
        check("bcd_1234_const", 32'(bus.bcd_out), 32'h01234);
`endif
        convert(16'd0);
        convert(16'd65535);
        convert(16'hFFFF);
        convert(16'h8000);
        convert(16'h7FFF);

        // Starts during SHIFT are ignored; exactly one done follows.
        start_conv(16'd9999);
        finish_conv(16'd9999, 1'b1);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("ignored_starts", 32'(extra), 32'd0);

        // Asynchronous reset mid-conversion aborts with no done.
        start_conv(16'd500);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(bus.bcd_out), 32'd0);
        check("abort_neg", 32'(bus.neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        convert(16'd77);

        // Back-to-back: start asserted during the done cycle.
        start_conv(16'd10);
        finish_conv(16'd10, 1'b0);
        start_conv(16'd20);
        finish_conv(16'd20, 1'b0);
        @(negedge clk);
        check("b2b_done_one_cycle", 32'(bus.done), 32'd0);

        for (int i = 0; i < 30; i++) begin
            v = 16'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            convert(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one iteration per clock.
- Sits directly upstream of the 7-segment hex display decoders.
- Takes the registered ALU result and produces one 4-bit BCD digit per display, so each display shows decimal 0-9 instead of hex.
- Uses a start/busy/done handshake so the ALU control logic can trigger a conversion whenever a new result is available.

Parameters:
- WIDTH, 16, bit width of the binary input.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH; an elaboration-time check fails the build otherwise.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  WIDTH  binary value to convert; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out and neg are updated.
- bcd_out  output  4*DIGITS  packed BCD digits; [3:0] = ones, [7:4] = tens, and so on.
- neg  output  1  sign of the last converted value; constant 0 unless SIGNED_INPUT_EN is defined.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, neg=0, iteration counter=0, internal shift register=0.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - capture the operand (see Optional Feature) into the shift register, BCD scratch=0.
  - counter=WIDTH, state->SHIFT, busy=1.
- IDLE, start=0: hold; done=0.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (all digits in parallel, combinational).
  - the {scratch, shift} register then shifts left by one.
  - counter decrements.
- Last iteration (counter==1):
  - register the final scratch into bcd_out.
  - update neg, done=1, busy=0, state->IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH (WIDTH cycles); busy high for exactly WIDTH cycles.
- done is high for exactly one cycle; it is 0 in every other cycle.
- start while busy=1 is ignored, with no queuing; bin_in changes during SHIFT have no effect.
- start high in the cycle done is high: the block is in IDLE, so it is accepted and a new conversion begins.
- bcd_out and neg hold the last completed result until the next done; they never show partial values.
- Reset mid-conversion aborts immediately to reset values; no done pulse is produced.
- Every digit of bcd_out is always in 0-9; unused upper digits are 0.

Optional Feature:
- Macro: SIGNED_INPUT_EN.
- Defined:
  - bin_in is two's complement.
  - On capture, if bin_in[WIDTH-1]=1, the shift register loads the magnitude (-bin_in, computed in WIDTH+1 bits so the most-negative value converts correctly) and neg is set at done.
  - Otherwise neg=0 at done.
- Not defined:
  - bin_in is unsigned; neg is tied to 0.
  - No negation logic is synthesized.

Test Plan:
- Reset, then start with bin_in=16'd1234 -> busy high 16 cycles, done pulse in cycle 16 after acceptance, bcd_out digits 0,1,2,3,4 (20'h01234), neg=0.
- bin_in=0 and bin_in=16'd65535 (unsigned build) -> bcd_out=20'h00000 and 20'h65535 respectively; no digit exceeds 9.
- Start with 16'd9999, pulse start again at cycles 3 and 10 with bin_in=16'd42 -> both ignored; single done with 20'h09999.
- Start with 16'd500, deassert rst_n at cycle 8 -> outputs reset immediately, no done; after release, start with 16'd77 -> 20'h00077.
- Back-to-back: assert start during the done cycle of 16'd10 with bin_in=16'd20 -> second done exactly 16 cycles later, 20'h00020.
- SIGNED_INPUT_EN build:
  - 16'hFFFF -> 20'h00001, neg=1.
  - 16'h8000 -> 20'h32768, neg=1.
  - 16'h7FFF -> 20'h32767, neg=0.
